fetch_controller: RTL and testbench
===================================

# fetch_controller

Per-wavefront instruction fetch sequencer on the consumer side of the PC block. Each fetch selects one eligible wavefront round-robin, reads and post-increments its PC through the PC block read port, and issues a single-outstanding instruction memory request. The returned instruction word is written into the instruction buffer, tagged with wavefront id, PC and first-fetch flag.

## Interface
- NUM_WF, 40: wavefront slots
- WF_ID_W, 6: wavefront id width
- PC_W, 32: PC / fetch address width
- INSTR_W, 32: instruction word width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- wf_valid  in  NUM_WF  wavefront slot active
- ibuff_full  in  NUM_WF  instruction buffer slot cannot accept
- pc_rd_en  out  1  PC read-and-increment strobe to PC block
- pc_wf_id_rd  out  WF_ID_W  PC block read index
- pc_rd_data  in  PC_W+1  {first_flag, pc}; combinational for pc_wf_id_rd; PC block increments on the edge where pc_rd_en=1
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  PC_W  fetch byte address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  instruction return, single cycle
- mem_rsp_data  in  INSTR_W  returned instruction
- ibuff_wr  out  1  instruction buffer write strobe
- ibuff_wf_id  out  WF_ID_W  target slot
- ibuff_instr  out  INSTR_W  instruction word
- ibuff_pc  out  PC_W  PC of instruction
- ibuff_first  out  1  first fetch after dispatch
- fetch_busy  out  1  state != IDLE
- perf_fetch_cnt  out  32  completed fetches (see Configuration)
- perf_drop_cnt  out  32  dropped responses (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, WRITE.
- Eligible vector: wf_valid & ~ibuff_full.
- IDLE: priority search starting at rr_ptr, wrapping NUM_WF-1 -> 0. If a hit exists: pc_rd_en=1, pc_wf_id_rd=hit, capture pc_rd_data into cur_pc/cur_first, cur_wf=hit, rr_ptr <= (hit+1) mod NUM_WF, go REQ. No hit: stay IDLE, pc_rd_en=0.
- REQ: mem_req_valid=1, mem_req_addr=cur_pc held stable until mem_req_ready; on ready go WAIT.
- WAIT: on mem_rsp_valid capture mem_rsp_data, go WRITE.
- WRITE: if wf_valid[cur_wf]=1, ibuff_wr=1 for one cycle with ibuff_wf_id=cur_wf, ibuff_pc=cur_pc, ibuff_first=cur_first; else drop (ibuff_wr=0). Go IDLE.
- Wavefront deactivated in REQ/WAIT: request still completes; response consumed and dropped at WRITE.
- ibuff_full rising after selection is ignored: selection guarantees one free entry and only one fetch is in flight.
- mem_rsp_valid outside WAIT is ignored.
- pc_wf_id_rd drives the search hit in IDLE, otherwise holds cur_wf.
- ibuff_* payload outputs hold last written values; valid only with ibuff_wr.

## Timing
- Reset (rst=0, async): state IDLE, rr_ptr=0, cur_* = 0, all outputs 0.
- Reset mid-operation aborts the fetch; outstanding response after reset is ignored (arrives in IDLE).
- Select cycle T: pc_rd_en=1. T+1: mem_req_valid=1. Ready at T+1 -> WAIT at T+2. Response at T+2 -> ibuff_wr at T+3. Minimum 4 cycles per fetch, next selection at T+4.
- pc_rd_en is never high outside IDLE; at most one pulse per fetch.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_fetch_cnt increments on each ibuff_wr; perf_drop_cnt increments on each dropped WRITE; both 32-bit wrapping, reset to 0.
- Not defined: both counters absent, outputs tied to 0.

## Test plan
- Single wf: wf_valid[5]=1, pc_rd_data={1,0x100}, ready and response immediate, data 0xBF810000 -> pc_rd_en at T with id 5, mem_req_addr=0x100 at T+1, ibuff_wr at T+3 with wf 5, pc 0x100, first=1.
- Round-robin: wf 0,1,39 valid -> selection order 0,1,39,0; after 39 rr_ptr wraps to 0.
- Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and addr stable 5 cycles, no second pc_rd_en.
- Kill in flight: wf_valid[3] drops during WAIT -> no ibuff_wr, state returns IDLE; with FETCH_PERF_CNT_EN perf_drop_cnt=1.
- Full slot skip: wf 2,4 valid, ibuff_full[2]=1 -> wf 4 selected; no select while all eligible masked.
- Async reset in WAIT then stray mem_rsp_valid -> all outputs 0, no ibuff_wr.

Source files
------------

// File: rtl/fetch_controller.sv
// Round-robin instruction fetch sequencer: one PC read, one memory request and one
// instruction-buffer write per fetch. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_controller #(
    parameter int unsigned NUM_WF  = 40,
    parameter int unsigned WF_ID_W = 6,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WF-1:0]   wf_valid,
    input  logic [NUM_WF-1:0]   ibuff_full,
    output logic                pc_rd_en,
    output logic [WF_ID_W-1:0]  pc_wf_id_rd,
    input  logic [PC_W:0]       pc_rd_data,
    output logic                mem_req_valid,
    output logic [PC_W-1:0]     mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [INSTR_W-1:0]  mem_rsp_data,
    output logic                ibuff_wr,
    output logic [WF_ID_W-1:0]  ibuff_wf_id,
    output logic [INSTR_W-1:0]  ibuff_instr,
    output logic [PC_W-1:0]     ibuff_pc,
    output logic                ibuff_first,
    output logic                fetch_busy,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_drop_cnt
);
    localparam int unsigned IDX_W = WF_ID_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t               state_q, state_d;
    logic [WF_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WF_ID_W-1:0]   cur_wf_q, cur_wf_d;
    logic [PC_W-1:0]      cur_pc_q, cur_pc_d;
    logic                 cur_first_q, cur_first_d;
    logic                 wr_q, wr_d;
    logic [WF_ID_W-1:0]   wr_wf_q, wr_wf_d;
    logic [INSTR_W-1:0]   wr_instr_q, wr_instr_d;
    logic [PC_W-1:0]      wr_pc_q, wr_pc_d;
    logic                 wr_first_q, wr_first_d;

    logic [NUM_WF-1:0]    elig;
    logic                 hit_found;
    logic [WF_ID_W-1:0]   hit_idx;
    logic [IDX_W-1:0]     idx;
    logic                 select_c;

    // Rotating priority search starting at rr_ptr, wrapping NUM_WF-1 -> 0
    always_comb begin
        elig      = wf_valid & ~ibuff_full;
        hit_found = 1'b0;
        hit_idx   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_WF; i++) begin
            idx = IDX_W'(rr_ptr_q) + IDX_W'(i);
            if (idx >= IDX_W'(NUM_WF)) begin
                idx = idx - IDX_W'(NUM_WF);
            end
            if (!hit_found && elig[idx[WF_ID_W-1:0]]) begin
                hit_found = 1'b1;
                hit_idx   = idx[WF_ID_W-1:0];
            end
        end
    end

    // The PC block is combinational on the read index, so the select strobe cannot be a flop
    assign select_c    = rst && (state_q == IDLE) && hit_found;
    assign pc_rd_en    = select_c;
    assign pc_wf_id_rd = select_c ? hit_idx : cur_wf_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_wf_d    = cur_wf_q;
        cur_pc_d    = cur_pc_q;
        cur_first_d = cur_first_q;
        wr_d        = 1'b0;
        wr_wf_d     = wr_wf_q;
        wr_instr_d  = wr_instr_q;
        wr_pc_d     = wr_pc_q;
        wr_first_d  = wr_first_q;
        case (state_q)
            IDLE: begin
                if (hit_found) begin
                    cur_wf_d                = hit_idx;
                    {cur_first_d, cur_pc_d} = pc_rd_data;
                    rr_ptr_d = (hit_idx == WF_ID_W'(NUM_WF - 1)) ? '0 : hit_idx + WF_ID_W'(1);
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A wavefront killed in flight still consumes its response, which is dropped
                if (mem_rsp_valid) begin
                    state_d = WRITE;
                    if (wf_valid[cur_wf_q]) begin
                        wr_d       = 1'b1;
                        wr_wf_d    = cur_wf_q;
                        wr_instr_d = mem_rsp_data;
                        wr_pc_d    = cur_pc_q;
                        wr_first_d = cur_first_q;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_wf_q    <= '0;
            cur_pc_q    <= '0;
            cur_first_q <= 1'b0;
            wr_q        <= 1'b0;
            wr_wf_q     <= '0;
            wr_instr_q  <= '0;
            wr_pc_q     <= '0;
            wr_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_wf_q    <= cur_wf_d;
            cur_pc_q    <= cur_pc_d;
            cur_first_q <= cur_first_d;
            wr_q        <= wr_d;
            wr_wf_q     <= wr_wf_d;
            wr_instr_q  <= wr_instr_d;
            wr_pc_q     <= wr_pc_d;
            wr_first_q  <= wr_first_d;
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = cur_pc_q;
    assign fetch_busy    = (state_q != IDLE);
    assign ibuff_wr      = wr_q;
    assign ibuff_wf_id   = wr_wf_q;
    assign ibuff_instr   = wr_instr_q;
    assign ibuff_pc      = wr_pc_q;
    assign ibuff_first   = wr_first_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // A WRITE cycle without the write strobe is a dropped response
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (wr_q) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == WRITE) && !wr_q) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with PC-block and memory models and a write scoreboard.
module tb_fetch_controller;
    localparam int unsigned NUM_WF = 40;

    logic        clk, rst;
    logic [39:0] wf_valid, ibuff_full;
    logic        pc_rd_en;
    logic [5:0]  pc_wf_id_rd;
    logic [32:0] pc_rd_data;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_rsp_data;
    logic        ibuff_wr, ibuff_first, fetch_busy;
    logic [5:0]  ibuff_wf_id;
    logic [31:0] ibuff_instr, ibuff_pc, perf_fetch_cnt, perf_drop_cnt;

    fetch_controller dut (
        .clk(clk), .rst(rst), .wf_valid(wf_valid), .ibuff_full(ibuff_full),
        .pc_rd_en(pc_rd_en), .pc_wf_id_rd(pc_wf_id_rd), .pc_rd_data(pc_rd_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .ibuff_wr(ibuff_wr), .ibuff_wf_id(ibuff_wf_id), .ibuff_instr(ibuff_instr),
        .ibuff_pc(ibuff_pc), .ibuff_first(ibuff_first), .fetch_busy(fetch_busy),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
    );

    always #5 clk = ~clk;

    // PC block model: combinational read, post-increment on a read strobe
    logic [31:0] pc_m [64];
    logic        first_m [64];
    assign pc_rd_data = {first_m[pc_wf_id_rd], pc_m[pc_wf_id_rd]};

    typedef struct {
        logic [5:0]  id;
        logic [31:0] pc;
        logic        first;
        logic [31:0] instr;
        int          sel;
        int          stall;
    } exp_t;

    exp_t sb[$];
    int   sel_log[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, mptr = 0, nsel = 0, req_cycles = 0, n_wr = 0;
    int   stall = 0, wait_cnt = 0, exp_fetch = 0, exp_drop = 0, kill_id = 0, pend_id = 0;
    bit   acc = 0, pend_rd = 0, kill_en = 0, rsp_en = 1, wr_seen = 0;
    logic [31:0] acc_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hBF80FF00 + a;
    endfunction

    function automatic int pick(input logic [39:0] el, input int ptr);
        for (int i = 0; i < NUM_WF; i++) begin
            int k;
            k = (ptr + i) % NUM_WF;
            if (el[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One cycle: observe at negedge, then update models and drive inputs just after posedge
    task automatic tick();
        exp_t e;
        int   p;
        @(negedge clk);
        cyc++;
        if (pc_rd_en === 1'b1) begin
            p = pick(wf_valid & ~ibuff_full, mptr);
            chk("pc_rd_en_while_busy", 64'(fetch_busy), 64'(0));
            chk("select_id", 64'(pc_wf_id_rd), 64'(p));
            if (p >= 0) begin
                e.id = 6'(p); e.pc = pc_m[p]; e.first = first_m[p];
                e.instr = instr_of(pc_m[p]); e.sel = cyc; e.stall = stall;
                sb.push_back(e);
                sel_log.push_back(p);
                mptr = (p + 1) % NUM_WF;
                exp_fetch++;
                pend_rd = 1; pend_id = p;
            end
            nsel++;
        end
        if (mem_req_valid === 1'b1) begin
            req_cycles++;
            if (sb.size() > 0) chk("req_addr", 64'(mem_req_addr), 64'(sb[$].pc));
            if (mem_req_ready) begin acc = 1; acc_addr = mem_req_addr; end
        end
        if (ibuff_wr === 1'b1) begin
            n_wr++; wr_seen = 1;
            if (sb.size() == 0) chk("unexpected_wr", 64'(1), 64'(0));
            else begin
                e = sb.pop_front();
                chk("wr_wf_id", 64'(ibuff_wf_id), 64'(e.id));
                chk("wr_pc", 64'(ibuff_pc), 64'(e.pc));
                chk("wr_first", 64'(ibuff_first), 64'(e.first));
                chk("wr_instr", 64'(ibuff_instr), 64'(e.instr));
                chk("wr_latency", 64'(cyc - e.sel), 64'(3 + e.stall));
            end
        end
        @(posedge clk); #1;
        if (pend_rd) begin pc_m[pend_id] += 32'd4; first_m[pend_id] = 1'b0; pend_rd = 0; end
        mem_rsp_valid = acc && rsp_en;
        mem_rsp_data  = acc ? instr_of(acc_addr) : 32'h0;
        if (acc && kill_en) begin
            wf_valid[kill_id] = 1'b0;
            void'(sb.pop_back());
            exp_fetch--; exp_drop++; kill_en = 0;
        end
        acc = 0;
        if (mem_req_valid) begin mem_req_ready = (wait_cnt >= stall); wait_cnt++; end
        else begin mem_req_ready = 0; wait_cnt = 0; end
    endtask

    task automatic reset_dut();
        rst = 0; wf_valid = '0; ibuff_full = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        sb.delete(); sel_log.delete();
        mptr = 0; acc = 0; wait_cnt = 0; pend_rd = 0; kill_en = 0; stall = 0; rsp_en = 1;
        exp_fetch = 0; exp_drop = 0; nsel = 0; req_cycles = 0; n_wr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic run_until_wr(input int max);
        wr_seen = 0;
        for (int i = 0; i < max && !wr_seen; i++) tick();
        if (!wr_seen) chk("timeout_wr", 64'(0), 64'(1));
    endtask

    // Stop new selections once the controller is back in IDLE
    task automatic drain(input int max);
        for (int i = 0; i < max && fetch_busy !== 1'b0; i++) tick();
        wf_valid = '0;
        chk("drain_idle", 64'(fetch_busy), 64'(0));
        chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_pc_rd_en"}, 64'(pc_rd_en), 64'(0));
        chk({pfx, "_pc_wf_id_rd"}, 64'(pc_wf_id_rd), 64'(0));
        chk({pfx, "_mem_req_valid"}, 64'(mem_req_valid), 64'(0));
        chk({pfx, "_mem_req_addr"}, 64'(mem_req_addr), 64'(0));
        chk({pfx, "_ibuff_wr"}, 64'(ibuff_wr), 64'(0));
        chk({pfx, "_ibuff_payload"}, {26'(0), ibuff_wf_id, ibuff_pc}, 64'(0));
        chk({pfx, "_ibuff_instr_first"}, {31'(0), ibuff_first, ibuff_instr}, 64'(0));
        chk({pfx, "_fetch_busy"}, 64'(fetch_busy), 64'(0));
        chk({pfx, "_perf"}, {perf_fetch_cnt, perf_drop_cnt}, 64'(0));
    endtask

    task automatic chk_perf(input string pfx);
`ifdef FETCH_PERF_CNT_EN
        chk({pfx, "_perf_fetch"}, 64'(perf_fetch_cnt), 64'(exp_fetch));
        chk({pfx, "_perf_drop"}, 64'(perf_drop_cnt), 64'(exp_drop));
`else
        chk({pfx, "_perf_tied"}, {perf_fetch_cnt, perf_drop_cnt}, 64'(0));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clk = 0;
        for (int i = 0; i < 64; i++) begin pc_m[i] = 32'h1000 * i; first_m[i] = 1'b1; end
        pc_m[5] = 32'h100;
        reset_dut();
        #1 chk_zero("reset");

        // Single wavefront, immediate ready and response
        wf_valid[5] = 1'b1;
        #1;
        chk("t0_pc_rd_en", 64'(pc_rd_en), 64'(1));
        chk("t0_pc_wf_id_rd", 64'(pc_wf_id_rd), 64'(5));
        tick(); #1;
        chk("t1_req_valid", 64'(mem_req_valid), 64'(1));
        chk("t1_req_addr", 64'(mem_req_addr), 64'(32'h100));
        chk("t1_no_pc_rd", 64'(pc_rd_en), 64'(0));
        tick(); #1;
        chk("t2_busy", 64'(fetch_busy), 64'(1));
        tick(); #1;
        chk("t3_ibuff_wr", 64'(ibuff_wr), 64'(1));
        chk("t3_ibuff_wf", 64'(ibuff_wf_id), 64'(5));
        chk("t3_ibuff_pc", 64'(ibuff_pc), 64'(32'h100));
        chk("t3_ibuff_first", 64'(ibuff_first), 64'(1));
        chk("t3_ibuff_instr", 64'(ibuff_instr), 64'(32'hBF810000));
        tick();
        wf_valid = '0;
        #1 chk("t4_idle", 64'(fetch_busy), 64'(0));
        chk_perf("single");

        // Round-robin with wrap from 39 back to 0
        reset_dut();
        wf_valid[0] = 1'b1; wf_valid[1] = 1'b1; wf_valid[39] = 1'b1;
        for (int i = 0; i < 40 && sel_log.size() < 4; i++) tick();
        drain(20);
        chk("rr_count", 64'(sel_log.size() >= 4), 64'(1));
        if (sel_log.size() >= 4) begin
            chk("rr_sel0", 64'(sel_log[0]), 64'(0));
            chk("rr_sel1", 64'(sel_log[1]), 64'(1));
            chk("rr_sel2", 64'(sel_log[2]), 64'(39));
            chk("rr_sel3", 64'(sel_log[3]), 64'(0));
        end
        chk_perf("rr");

        // Memory backpressure for 5 cycles
        reset_dut();
        stall = 5;
        wf_valid[6] = 1'b1;
        run_until_wr(30);
        drain(10);
        chk("bp_selects", 64'(nsel), 64'(1));
        chk("bp_req_cycles", 64'(req_cycles), 64'(6));
        stall = 0;
        chk_perf("bp");

        // Kill in flight: wavefront drops during WAIT
        reset_dut();
        wf_valid[3] = 1'b1; kill_en = 1; kill_id = 3;
        repeat (8) tick();
        chk("kill_done", 64'(kill_en), 64'(0));
        chk("kill_no_wr", 64'(n_wr), 64'(0));
        chk("kill_idle", 64'(fetch_busy), 64'(0));
        chk("kill_sb_empty", 64'(sb.size()), 64'(0));
        chk_perf("kill");

        // Full slot skipped; nothing selected while all eligible slots are masked
        reset_dut();
        wf_valid[2] = 1'b1; wf_valid[4] = 1'b1; ibuff_full[2] = 1'b1;
        run_until_wr(10);
        chk("skip_sel", 64'(sel_log.size() > 0 ? sel_log[0] : -1), 64'(4));
        ibuff_full[4] = 1'b1;
        n = nsel;
        repeat (10) tick();
        chk("masked_no_select", 64'(nsel), 64'(n));
        chk("masked_idle", 64'(fetch_busy), 64'(0));
        wf_valid = '0; ibuff_full = '0;
        chk_perf("skip");

        // Async reset in WAIT, then a stray response
        reset_dut();
        rsp_en = 0;
        wf_valid[7] = 1'b1;
        tick(); tick(); #1;
        chk("rst_in_wait_busy", 64'(fetch_busy), 64'(1));
        chk("rst_in_wait_noreq", 64'(mem_req_valid), 64'(0));
        wf_valid = '0; sb.delete();
        #2 rst = 0;
        #1 chk_zero("async_rst");
        @(posedge clk); #1;
        rst = 1; mptr = 0; exp_fetch = 0; exp_drop = 0; n_wr = 0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
        repeat (4) tick();
        #1;
        chk("stray_no_wr", 64'(n_wr), 64'(0));
        chk_zero("after_stray");
        rsp_en = 1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
